vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Shares one single-port synchronous framebuffer RAM between the VGA scanout path and a pixel-writing client (drawing engine/CPU bridge). Scanout is fed from an internal prefetch FIFO kept topped up by read bursts in idle memory slots. Display refill pre-empts writes whenever the FIFO runs low. Sits between the 40 MHz timing generator and the framebuffer RAM, in the CLK domain.

## Interface
- FB_WORDS, 480000: framebuffer words, one per pixel (800x600).
- ADDR_W, 19: RAM address width.
- DATA_W, 8: pixel word width.
- DEPTH, 16: prefetch FIFO entries, power of two.
- LOW_WATER, 4: fill level below which display is urgent.

- CLK  in  1  pixel clock. One clock only.
- RST  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse before first active pixel of a frame.
- disp_pop  in  1  scanout consumes head pixel this cycle.
- disp_valid  out  1  FIFO non-empty.
- disp_pixel  out  DATA_W  FIFO head (show-ahead); 0 when empty.
- underflow  out  1  sticky: pop seen while empty.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer grant.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- mem_en  out  1  RAM access strobe, registered.
- mem_we  out  1  RAM write, registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_rdata  in  DATA_W  valid the cycle after a read is presented.

## Operation
- fill = fifo_count + reads in flight (0..2). All decisions use registered fill.
- urgent = fill < LOW_WATER.
- Per-cycle grant, in priority order:
  - frame_start: no grant.
  - urgent: display read.
  - wr_valid: write.
  - fill < DEPTH: display read.
  - otherwise: idle.
- wr_ready = !RST && !frame_start && !urgent. It does not depend on wr_valid. A write transfers on wr_valid && wr_ready.
- Display read:
  - Issues at fetch_addr.
  - fetch_addr increments and wraps FB_WORDS-1 -> 0.
  - Returned word is pushed into the FIFO.
- The credit rule (fill < DEPTH) guarantees no FIFO overflow.
- frame_start:
  - fetch_addr <= 0.
  - FIFO cleared.
  - In-flight read valid bits cleared; their data is dropped on return.
  - underflow cleared.
  - A write in flight still completes.
- disp_pop:
  - On a non-empty FIFO, removes the head.
  - On an empty FIFO, sets underflow; disp_pixel stays 0.
  - Push and pop in the same cycle leave count unchanged.
- Reset values: mem_en, mem_we, mem_addr, mem_wdata = 0; FIFO empty; disp_valid = 0; disp_pixel = 0; underflow = 0; wr_ready = 0; fetch_addr = 0; in-flight bits = 0.

## Timing
- Grant in cycle t: mem_* carry the access in t+1. For a read, mem_rdata is sampled at t+2 and the word is visible at disp_pixel in t+3.
- Cold-start latency: frame_start at t0, first fetch granted t0+1, disp_valid high at t0+4.
- Writer latency: handshake at t, RAM write at t+1. A read to the same address granted at t+1 or later returns the new data.
- Max writer stall after urgency ends: 0 cycles. Writer starvation is bounded by refill time to LOW_WATER.
- Sustained scanout of 1 pixel/cycle consumes all slots. Writes get bandwidth only in blanking.
- RST asserted mid-burst: all state returns to reset values at the next edge. Returning read data is ignored.

## Structure
- Shared package vga_fb_pkg holds:
  - default FB_WORDS, ADDR_W, DATA_W constants;
  - grant enum GNT_NONE / GNT_DISP / GNT_WR.
- One sub-module, vga_pix_fifo: synchronous show-ahead FIFO with DEPTH entries, push/pop/count/empty, same reset.
- Arbiter logic (grant, fetch_addr, 2-stage in-flight valid pipe, mem_* registers) lives in the top.

## Test plan
- Reset, then frame_start, no writer: fetch addresses 0,1,2,… appear on mem_addr. FIFO reaches 16 and no further reads issue. disp_valid rises at t0+4.
- Continuous disp_pop with RAM word = address[7:0]: disp_pixel sequence 0x00,0x01,…,0xFF,0x00. underflow stays 0.
- FIFO full, wr_valid held with wr_addr=0x00010, data 0xA5: wr_ready=1. mem_we=1, mem_addr=0x00010, mem_wdata=0xA5 next cycle. A later fetch of 0x00010 returns 0xA5.
- Pops drain fill to 3 while wr_valid=1: wr_ready drops the same cycle and display reads take the slots. wr_ready returns once fill ≥ 4.
- frame_start with 2 reads in flight and FIFO at 10: FIFO empties, both returning words are discarded, next read is at address 0.
- Pop while empty: underflow=1 and disp_pixel=0. underflow stays set until the next frame_start.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// ----------------------------------------------------------------------------
// vga_fb_pkg
//   Constants and types shared by the framebuffer arbiter and its FIFO.
//   - DEF_FB_WORDS / DEF_ADDR_W / DEF_DATA_W : default 800x600x8bpp geometry
//   - grant_e : which client owns the RAM slot in the current cycle
// ----------------------------------------------------------------------------
package vga_fb_pkg;

    localparam int DEF_FB_WORDS = 480000;
    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_DATA_W   = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

endpackage

// File: rtl/vga_pix_fifo.sv
// ----------------------------------------------------------------------------
// vga_pix_fifo
//   Synchronous show-ahead FIFO feeding the scanout path.
//   Ports:
//     CLK, RST   : clock, synchronous active-high reset
//     clr        : flush to empty (new frame); wins over push/pop
//     push       : write push_data at the tail
//     push_data  : word to store
//     pop        : remove the head; ignored while empty
//     head       : current head word, 0 while empty
//     empty      : no entries stored
//     count      : number of entries stored (0..DEPTH)
// ----------------------------------------------------------------------------
module vga_pix_fifo
    import vga_fb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         clr,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge value of every other flop.
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, and an empty FIFO presents 0 on head.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter
//   Shares one single-port synchronous framebuffer RAM between VGA scanout
//   (fed from a prefetch FIFO) and a pixel-writing client. Display refill
//   pre-empts writes whenever the FIFO runs low.
//   Ports:
//     CLK, RST     : pixel clock, synchronous active-high reset
//     frame_start  : restart fetch at address 0 and flush the FIFO
//     disp_pop     : scanout consumes the head pixel
//     disp_valid   : FIFO non-empty
//     disp_pixel   : FIFO head, 0 while empty
//     underflow    : sticky, pop seen while empty; cleared by frame_start
//     wr_valid/wr_ready/wr_addr/wr_data : writer handshake
//     mem_en/mem_we/mem_addr/mem_wdata  : registered RAM request
//     mem_rdata    : RAM read data, valid the cycle after the read
// ----------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FB_WORDS  = DEF_FB_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 16,
    parameter int LOW_WATER = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              frame_start,
    input  logic              disp_pop,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_pixel,
    output logic              underflow,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FILL_W = $clog2(DEPTH + 3);

    grant_e            grant;
    logic [FILL_W-1:0] fill;
    logic              urgent;

    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Read pipe: s1 = read presented to RAM this cycle, s2 = its data on
    // mem_rdata this cycle (pushed at the end of the cycle).
    logic              rd_s1_q, rd_s1_d;
    logic              rd_s2_q, rd_s2_d;

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              underflow_q, underflow_d;

    // Fill counts reads already in flight so the credit check never
    // over-commits the FIFO.
    assign fill   = FILL_W'(fifo_count) + FILL_W'(rd_s1_q) + FILL_W'(rd_s2_q);
    assign urgent = (fill < FILL_W'(LOW_WATER));

    // Ready is independent of wr_valid so the writer can rely on it.
    assign wr_ready = !RST && !frame_start && !urgent;

    always_comb begin
        grant = GNT_NONE;
        if (frame_start)                     grant = GNT_NONE;
        else if (urgent)                     grant = GNT_DISP;
        else if (wr_valid)                   grant = GNT_WR;
        else if (fill < FILL_W'(DEPTH))      grant = GNT_DISP;
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        // Address/data hold across idle cycles to avoid bus toggling.
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_s1_d      = (grant == GNT_DISP);
        // A read already presented when the frame restarts is dropped.
        rd_s2_d      = rd_s1_q && !frame_start;
        underflow_d  = underflow_q || (disp_pop && fifo_empty);

        case (grant)
            GNT_DISP: begin
                mem_en_d     = 1'b1;
                mem_addr_d   = fetch_addr_q;
                fetch_addr_d = (fetch_addr_q == ADDR_W'(FB_WORDS - 1))
                             ? '0 : fetch_addr_q + ADDR_W'(1);
            end
            GNT_WR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
            end
            default: ;
        endcase

        if (frame_start) begin
            fetch_addr_d = '0;
            underflow_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_addr_q <= '0;
            rd_s1_q      <= 1'b0;
            rd_s2_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            underflow_q  <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            rd_s1_q      <= rd_s1_d;
            rd_s2_q      <= rd_s2_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            underflow_q  <= underflow_d;
        end
    end

    // Flush on frame_start takes priority over a returning word, which is
    // exactly what discards data from reads issued before the restart.
    vga_pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (frame_start),
        .push      (rd_s2_q),
        .push_data (mem_rdata),
        .pop       (disp_pop),
        .head      (disp_pixel),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign disp_valid = !fifo_empty;
    assign underflow  = underflow_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//   Directed bench for vga_fb_arbiter with a behavioural single-port RAM whose
//   unwritten words read back as address[7:0].
// ----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int NV = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          disp_pop;
    logic          disp_valid;
    logic [DW-1:0] disp_pixel;
    logic          underflow;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int exp_pix = 0;
    bit wrote = 1'b0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .CLK         (clk),
        .RST         (rst),
        .frame_start (frame_start),
        .disp_pop    (disp_pop),
        .disp_valid  (disp_valid),
        .disp_pixel  (disp_pixel),
        .underflow   (underflow),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // RAM model: a small log of written words, newest entry wins.
    logic [AW-1:0] log_addr [16];
    logic [DW-1:0] log_data [16];
    int            wr_n = 0;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        int idx;
        for (int j = 0; j < 16 && j < wr_n; j++) begin
            idx = (wr_n - 1 - j) % 16;
            if (log_addr[idx] == a) return log_data[idx];
        end
        return a[7:0];
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            log_addr[wr_n % 16] <= mem_addr;
            log_data[wr_n % 16] <= mem_wdata;
            wr_n                <= wr_n + 1;
        end else if (mem_en) begin
            mem_rdata <= ram_word(mem_addr);
        end
    end

    typedef struct {
        logic          fs;
        logic          dv;
        logic          wrdy;
        logic          en;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vecs [NV];

    task automatic set_vec(input int k, input logic fs, input logic dv,
                           input logic wrdy, input logic en, input int addr);
        vecs[k].fs   = fs;
        vecs[k].dv   = dv;
        vecs[k].wrdy = wrdy;
        vecs[k].en   = en;
        vecs[k].addr = AW'(addr);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int n);
        logic [31:0] v;
        v = n;
        if (wrote && n == 16) return 8'hA5;
        return v[7:0];
    endfunction

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input logic fs, input logic pop, input logic wv);
        frame_start = fs;
        disp_pop    = pop;
        wr_valid    = wv;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_pop_pixel(input string name);
        check(name, disp_pixel, exp_word(exp_pix));
        exp_pix++;
    endtask

    initial begin
        // Cold-start frame: row k is cycle t0+k, frame_start at row 0 with a
        // full FIFO holding addresses 0..15 from the post-reset prefill.
        set_vec(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        set_vec(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        set_vec(2, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        set_vec(3, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        set_vec(4, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        for (int k = 5; k <= 17; k++) set_vec(k, 1'b0, 1'b1, 1'b1, 1'b1, k - 2);
        for (int k = 18; k < NV; k++) set_vec(k, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        rst         = 1'b1;
        frame_start = 1'b0;
        disp_pop    = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = 19'h00010;
        wr_data     = 8'hA5;

        // ---- reset state ----
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("rst disp_valid", disp_valid, 0);
        check("rst disp_pixel", disp_pixel, 0);
        check("rst wr_ready",   wr_ready,   0);
        check("rst mem_en",     mem_en,     0);
        check("rst mem_addr",   mem_addr,   0);
        check("rst underflow",  underflow,  0);
        next_cycle();
        rst = 1'b0;
        repeat (25) next_cycle();

        // ---- cold start table ----
        for (int k = 0; k < NV; k++) begin
            apply(vecs[k].fs, 1'b0, 1'b0);
            check($sformatf("cold[%0d] disp_valid", k), disp_valid, vecs[k].dv);
            check($sformatf("cold[%0d] disp_pixel", k), disp_pixel, 0);
            check($sformatf("cold[%0d] wr_ready", k),   wr_ready,   vecs[k].wrdy);
            check($sformatf("cold[%0d] mem_en", k),     mem_en,     vecs[k].en);
            check($sformatf("cold[%0d] mem_we", k),     mem_we,     0);
            check($sformatf("cold[%0d] underflow", k),  underflow,  0);
            if (vecs[k].en) check($sformatf("cold[%0d] mem_addr", k), mem_addr, vecs[k].addr);
            next_cycle();
        end

        // ---- continuous scanout: 0x00..0xFF,0x00 ----
        exp_pix = 0;
        for (int i = 0; i < 257; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            check($sformatf("scan[%0d] disp_valid", i), disp_valid, 1);
            check_pop_pixel($sformatf("scan[%0d] disp_pixel", i));
            next_cycle();
        end
        repeat (6) begin
            apply(1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        apply(1'b0, 1'b0, 1'b0);
        check("scan underflow", underflow, 0);
        check("full idle mem_en", mem_en, 0);

        // ---- write with FIFO full ----
        apply(1'b0, 1'b0, 1'b1);
        check("wr full wr_ready", wr_ready, 1);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("wr mem_en",    mem_en,    1);
        check("wr mem_we",    mem_we,    1);
        check("wr mem_addr",  mem_addr,  19'h00010);
        check("wr mem_wdata", mem_wdata, 8'hA5);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("wr done mem_en", mem_en, 0);

        // ---- drain to fill 3 with writer pending ----
        for (int i = 0; i < 13; i++) begin
            apply(1'b0, 1'b1, 1'b1);
            check($sformatf("drain[%0d] wr_ready", i), wr_ready, 1);
            check_pop_pixel($sformatf("drain[%0d] disp_pixel", i));
            if (i > 0) check($sformatf("drain[%0d] mem_we", i), mem_we, 1);
            next_cycle();
        end
        apply(1'b0, 1'b0, 1'b1);
        check("low wr_ready", wr_ready, 0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b1);
        check("low read mem_en",   mem_en,   1);
        check("low read mem_we",   mem_we,   0);
        check("low read mem_addr", mem_addr, AW'(exp_pix + 3));
        check("fill4 wr_ready",    wr_ready, 1);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("resume mem_we", mem_we, 1);
        next_cycle();
        repeat (20) begin
            apply(1'b0, 1'b0, 1'b0);
            next_cycle();
        end

        // ---- frame_start with FIFO at 10 and two reads in flight ----
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, 1'b1);
            check_pop_pixel($sformatf("fs drain[%0d] disp_pixel", i));
            next_cycle();
        end
        apply(1'b0, 1'b0, 1'b0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        next_cycle();
        apply(1'b1, 1'b0, 1'b0);
        check("fs wr_ready", wr_ready, 0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("fs+1 disp_valid", disp_valid, 0);
        check("fs+1 mem_en",     mem_en,     0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("fs+2 disp_valid", disp_valid, 0);
        check("fs+2 mem_en",     mem_en,     1);
        check("fs+2 mem_addr",   mem_addr,   0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("fs+3 disp_valid", disp_valid, 0);
        check("fs+3 mem_addr",   mem_addr,   1);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("fs+4 disp_valid", disp_valid, 1);
        check("fs+4 disp_pixel", disp_pixel, 0);
        next_cycle();

        // ---- new frame readback, address 0x10 holds the written word ----
        exp_pix = 0;
        wrote   = 1'b1;
        repeat (16) begin
            apply(1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            check_pop_pixel($sformatf("frame2[%0d] disp_pixel", i));
            next_cycle();
        end

        // ---- reset mid-burst, then pop while empty ----
        rst = 1'b1;
        apply(1'b0, 1'b0, 1'b0);
        check("midrst wr_ready", wr_ready, 0);
        next_cycle();
        rst = 1'b0;
        apply(1'b0, 1'b1, 1'b0);
        check("postrst disp_valid", disp_valid, 0);
        check("postrst disp_pixel", disp_pixel, 0);
        check("postrst mem_en",     mem_en,     0);
        check("postrst mem_we",     mem_we,     0);
        check("postrst mem_addr",   mem_addr,   0);
        check("postrst mem_wdata",  mem_wdata,  0);
        check("postrst underflow",  underflow,  0);
        check("postrst wr_ready",   wr_ready,   0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("uflow set",        underflow,  1);
        check("uflow disp_pixel", disp_pixel, 0);
        check("uflow disp_valid", disp_valid, 0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("postrst first disp_valid", disp_valid, 1);
        check("postrst first disp_pixel", disp_pixel, 0);
        check("uflow sticky",             underflow,  1);
        next_cycle();
        repeat (5) begin
            apply(1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        apply(1'b1, 1'b0, 1'b0);
        check("uflow before fs", underflow, 1);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0);
        check("uflow cleared", underflow, 0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
